// File: rtl/project_select_ctrl.sv
// Wishbone-configurable selector that enables at most one user project at a time,
// with a break-before-make guard gap and a completion interrupt on every switch.
module project_select_ctrl #(
   parameter int          N_PROJ        = 2,
   parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
   parameter int          GUARD_DEFAULT = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [N_PROJ-1:0] active,
   output logic              irq
);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_ON    = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]        state_r, state_next_s;
   logic [15:0]       cnt_r, cnt_next_s;
   logic [3:0]        cur_idx_r, cur_idx_next_s;
   logic              switch_done_s;
   logic [N_PROJ-1:0] active_r, active_next_s;
   logic              irq_r;

   logic              ack_r;
   logic [31:0]       dat_r, rd_data_s;
   logic              ctrl_en_r, done_r, err_r;
   logic [3:0]        ctrl_idx_r;
   logic [15:0]       guard_r;

   logic hit_s, wr_s, wr_ctrl_s, wr_guard_s, wr_status_s;
   logic req_en_s, req_bad_s, req_s, tgt_en_s;
   logic [3:0] req_idx_s, tgt_idx_s;
   logic unused_s;

   assign hit_s       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   // Register side effects happen in the ack cycle while the master still holds the bus.
   assign wr_s        = ack_r & hit_s & wbs_we_i;
   assign wr_ctrl_s   = wr_s & (wbs_adr_i[3:2] == 2'd0);
   assign wr_guard_s  = wr_s & (wbs_adr_i[3:2] == 2'd1);
   assign wr_status_s = wr_s & (wbs_adr_i[3:2] == 2'd2);
   assign req_en_s    = wbs_dat_i[8];
   assign req_idx_s   = wbs_dat_i[3:0];
   assign req_bad_s   = req_en_s & ({1'b0, req_idx_s} >= 5'(N_PROJ));
   assign req_s       = wr_ctrl_s & ~req_bad_s;
   // A request landing on the expiry edge still redirects the switch.
   assign tgt_en_s    = req_s ? req_en_s : ctrl_en_r;
   assign tgt_idx_s   = req_s ? req_idx_s : ctrl_idx_r;
   assign unused_s    = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:16]};

   // State register for the switch sequencer
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_r   <= ST_OFF;
         cnt_r     <= 16'd0;
         cur_idx_r <= 4'd0;
      end else begin
         state_r   <= state_next_s;
         cnt_r     <= cnt_next_s;
         cur_idx_r <= cur_idx_next_s;
      end
   end

   // Next-state logic: OFF/ON react to requests, DRAIN counts out the guard gap
   always_comb begin
      state_next_s   = state_r;
      cnt_next_s     = cnt_r;
      cur_idx_next_s = cur_idx_r;
      switch_done_s  = 1'b0;
      case (state_r)
         ST_OFF: begin
            if (req_s && req_en_s) begin
               state_next_s   = ST_ON;
               cur_idx_next_s = req_idx_s;
               switch_done_s  = 1'b1;
            end else begin
               state_next_s = ST_OFF;
            end
         end
         ST_ON: begin
            if (req_s && !(req_en_s && (req_idx_s == cur_idx_r))) begin
               state_next_s = ST_DRAIN;
               cnt_next_s   = (guard_r == 16'd0) ? 16'd1 : guard_r;
            end else begin
               state_next_s = ST_ON;
            end
         end
         ST_DRAIN: begin
            cnt_next_s = cnt_r - 16'd1;
            if (cnt_r == 16'd1) begin
               switch_done_s = 1'b1;
               if (tgt_en_s) begin
                  state_next_s   = ST_ON;
                  cur_idx_next_s = tgt_idx_s;
               end else begin
                  state_next_s = ST_OFF;
               end
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         default: begin
            state_next_s = ST_OFF;
            cnt_next_s   = 16'd0;
         end
      endcase
   end

   // Output decode from the upcoming state so enables and irq line up with it
   always_comb begin
      active_next_s = '0;
      if (state_next_s == ST_ON) begin
         for (int i = 0; i < N_PROJ; i++) begin
            active_next_s[i] = (cur_idx_next_s == 4'(i));
         end
      end else begin
         active_next_s = '0;
      end
   end

   // Registered enables and interrupt
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         active_r <= '0;
         irq_r    <= 1'b0;
      end else begin
         active_r <= active_next_s;
         irq_r    <= switch_done_s;
      end
   end

   // Configuration registers and sticky flags; a set beats a same-cycle clear
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ctrl_en_r  <= 1'b0;
         ctrl_idx_r <= 4'd0;
         guard_r    <= 16'(GUARD_DEFAULT);
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         if (req_s) begin
            ctrl_en_r  <= req_en_s;
            ctrl_idx_r <= req_idx_s;
         end
         if (wr_guard_s) begin
            guard_r <= wbs_dat_i[15:0];
         end
         done_r <= switch_done_s | (done_r & ~(wr_status_s & wbs_dat_i[10]));
         err_r  <= (wr_ctrl_s & req_bad_s) | (err_r & ~(wr_status_s & wbs_dat_i[11]));
      end
   end

   // Read data mux
   always_comb begin
      rd_data_s = 32'd0;
      case (wbs_adr_i[3:2])
         2'd0:    rd_data_s = {23'd0, ctrl_en_r, 4'd0, ctrl_idx_r};
         2'd1:    rd_data_s = {16'd0, guard_r};
         2'd2:    rd_data_s = {20'd0, err_r, done_r, (state_r == ST_DRAIN),
                               (state_r == ST_ON), 4'd0, cur_idx_r};
         default: rd_data_s = 32'd0;
      endcase
   end

   // Single-cycle ack with a mandatory idle cycle between acks
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_r <= 1'b0;
         dat_r <= 32'd0;
      end else begin
         ack_r <= hit_s & ~ack_r;
         dat_r <= (hit_s & ~ack_r & ~wbs_we_i) ? rd_data_s : 32'd0;
      end
   end

   assign wbs_ack_o = ack_r;
   assign wbs_dat_o = dat_r;
   assign active    = active_r;
   assign irq       = irq_r;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Bench for project_select_ctrl: directed scenarios plus random bus traffic,
// every cycle compared against a transaction-level model of the switch rules.
module tb_project_select_ctrl;

   localparam int          NP   = 2;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = 32'd0, wdat = 32'd0;
   logic        ack;
   logic [31:0] rdat;
   logic [NP-1:0] active;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   project_select_ctrl #(.N_PROJ(NP), .BASE_ADDR(BASE), .GUARD_DEFAULT(16)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
      .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
      .wbs_ack_o(ack), .wbs_dat_o(rdat), .active(active), .irq(irq));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Inputs as seen by the DUT at each rising edge
   logic        s_rst = 1'b0, s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
   logic [31:0] s_adr = 32'd0, s_dat = 32'd0;
   always @(posedge clk) begin
      s_rst <= rst_n; s_cyc <= cyc; s_stb <= stb; s_we <= we;
      s_adr <= adr;   s_dat <= wdat;
   end

   // Model: which project is enabled (-1 none), guard cycles still to wait, and registers
   int          m_proj = -1, m_left = 0, m_cur = 0, m_ctrl_idx = 0, m_guard = 16;
   bit          m_ctrl_en = 0, m_done = 0, m_err = 0, m_ack = 0;
   logic [31:0] e_dat = 32'd0;
   bit          e_irq = 0;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case ((a >> 2) & 32'd3)
         32'd0:   return (m_ctrl_en ? 32'h100 : 32'h0) | 32'(m_ctrl_idx);
         32'd1:   return 32'(m_guard);
         32'd2:   return (m_err ? 32'h800 : 32'h0) | (m_done ? 32'h400 : 32'h0) |
                         ((m_left > 0) ? 32'h200 : 32'h0) | ((m_proj >= 0) ? 32'h100 : 32'h0) |
                         32'(m_cur);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      bit hit, ack_new, wr, req, err_set, clr_done, clr_err;
      int off, en, idx;
      hit = s_cyc && s_stb && ((s_adr >> 4) == (BASE >> 4));
      if (!s_rst) begin
         m_proj = -1; m_left = 0; m_cur = 0; m_ctrl_idx = 0; m_ctrl_en = 0;
         m_guard = 16; m_done = 0; m_err = 0; m_ack = 0; e_dat = 0; e_irq = 0;
         return;
      end
      ack_new = hit && !m_ack;
      e_dat = (ack_new && !s_we) ? model_read(s_adr) : 32'd0;
      wr = m_ack && hit && s_we;
      off = int'((s_adr >> 2) & 32'd3);
      req = 0; err_set = 0; e_irq = 0;
      clr_done = wr && off == 2 && s_dat[10];
      clr_err  = wr && off == 2 && s_dat[11];
      if (wr && off == 0) begin
         en = int'(s_dat[8]); idx = int'(s_dat[3:0]);
         if (en == 1 && idx >= NP) err_set = 1;
         else begin req = 1; m_ctrl_en = (en == 1); m_ctrl_idx = idx; end
      end
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            e_irq = 1;
            if (m_ctrl_en) begin m_proj = m_ctrl_idx; m_cur = m_ctrl_idx; end
         end
      end else if (m_proj >= 0) begin
         if (req && !(m_ctrl_en && m_ctrl_idx == m_proj)) begin
            m_proj = -1;
            m_left = (m_guard == 0) ? 1 : m_guard;
         end
      end else if (req && m_ctrl_en) begin
         m_proj = m_ctrl_idx; m_cur = m_ctrl_idx; e_irq = 1;
      end
      if (wr && off == 1) m_guard = int'(s_dat[15:0]);
      if (e_irq) m_done = 1; else if (clr_done) m_done = 0;
      if (err_set) m_err = 1; else if (clr_err) m_err = 0;
      m_ack = ack_new;
   endtask

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         model_step();
         check_eq("ack", 32'(ack), 32'(m_ack));
         check_eq("dat", rdat, e_dat);
         check_eq("irq", 32'(irq), 32'(e_irq));
         check_eq("active", 32'(active), (m_proj >= 0) ? (32'd1 << m_proj) : 32'd0);
      end
   end

   task automatic wb_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                          output logic [31:0] r, output bit ok);
      @(negedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
      ok = 0; r = 32'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) begin ok = 1; r = rdat; break; end
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
      logic [31:0] r; bit ok;
      wb_xfer(BASE + off, 1'b1, d, r, ok);
      check_eq("wr_ack", 32'(ok), 32'd1);
   endtask

   task automatic rd_reg(input logic [31:0] off, output logic [31:0] r);
      bit ok;
      wb_xfer(BASE + off, 1'b0, 32'd0, r, ok);
      check_eq("rd_ack", 32'(ok), 32'd1);
   endtask

   task automatic count_gap(output int zeros);
      zeros = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (active != '0) break;
         zeros++;
      end
   endtask

   initial begin
      logic [31:0] r;
      bit ok;
      int z, nirq;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      rd_reg(32'h4, r); check_eq("guard_rst", r, 32'd16);
      rd_reg(32'h8, r); check_eq("status_rst", r, 32'd0);
      check_eq("active_rst", 32'(active), 32'd0);
      wb_xfer(BASE + 32'h20, 1'b0, 32'd0, r, ok); check_eq("oow_noack", 32'(ok), 32'd0);

      wr_reg(32'h0, 32'h100);
      @(negedge clk);
      check_eq("on0_active", 32'(active), 32'd1);
      check_eq("on0_irq", 32'(irq), 32'd1);
      rd_reg(32'h8, r); check_eq("on0_status", r, 32'h500);

      wr_reg(32'h4, 32'd3);
      wr_reg(32'h0, 32'h101);
      count_gap(z);
      check_eq("gap3_len", 32'(z), 32'd3);
      check_eq("gap3_active", 32'(active), 32'd2);
      check_eq("gap3_irq", 32'(irq), 32'd1);

      // ON(1) -> ON(0), then redirect the pending switch to OFF
      wr_reg(32'h0, 32'h100);
      repeat (6) @(negedge clk);
      wr_reg(32'h4, 32'd6);
      wr_reg(32'h0, 32'h101);
      wr_reg(32'h0, 32'h000);
      nirq = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (irq) nirq++;
      end
      check_eq("redir_irqs", 32'(nirq), 32'd1);
      check_eq("redir_active", 32'(active), 32'd0);

      wr_reg(32'h0, 32'h100);
      repeat (2) @(negedge clk);
      wr_reg(32'h0, 32'h105);
      rd_reg(32'h8, r); check_eq("err_set", r & 32'hB0F, 32'h900);
      check_eq("err_active", 32'(active), 32'd1);
      rd_reg(32'h0, r); check_eq("err_ctrl", r, 32'h100);
      wr_reg(32'h8, 32'h800);
      rd_reg(32'h8, r); check_eq("err_clr", r & 32'h800, 32'd0);

      wr_reg(32'h4, 32'd0);
      wr_reg(32'h0, 32'h101);
      count_gap(z);
      check_eq("gap0_len", 32'(z), 32'd1);
      check_eq("gap0_active", 32'(active), 32'd2);

      wr_reg(32'h4, 32'd20);
      wr_reg(32'h0, 32'h100);
      rd_reg(32'h8, r); check_eq("busy", r & 32'h300, 32'h200);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_active", 32'(active), 32'd0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      rd_reg(32'h8, r); check_eq("rst_status", r, 32'd0);
      rd_reg(32'h4, r); check_eq("rst_guard", r, 32'd16);

      // Random traffic; the cycle monitor does the checking
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0, 1: wb_xfer(BASE, 1'b1, {23'd0, 1'($urandom_range(0, 1)), 4'd0,
                          4'($urandom_range(0, 3))}, r, ok);
            2:    wb_xfer(BASE + 32'h4, 1'b1, 32'($urandom_range(0, 6)), r, ok);
            3:    wb_xfer(BASE + 32'h8, 1'b1, 32'($urandom) & 32'hC00, r, ok);
            4:    wb_xfer(BASE + 32'(4 * $urandom_range(0, 3)), 1'b0, 32'd0, r, ok);
            default: wb_xfer(BASE + 32'h10 + 32'(4 * $urandom_range(0, 15)),
                             1'($urandom_range(0, 1)), 32'h101, r, ok);
         endcase
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/project_select_ctrl.md
Name: project_select_ctrl

Overview:
- Wishbone-configurable controller that generates the per-project `active` enables for the user projects sharing the user_project_wrapper IO, LA and Wishbone buses.
- Guarantees at most one project is active at any time.
- Every switch is break-before-make: all enables are low for a programmable guard interval before the next project is enabled.
- Raises an interrupt pulse when each switch completes.

Parameters:
- N_PROJ, 2, number of projects driven; 1..16.
- BASE_ADDR, 32'h3000_0000, Wishbone base address; the block decodes 16 bytes from here.
- GUARD_DEFAULT, 16, reset value of the GUARD register in cycles.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; ignored, full-word access only.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge, asserted only for in-window addresses.
- wbs_dat_o  out  32  read data; 0 when not acking.
- active  out  N_PROJ  one-hot or all-zero project enables.
- irq  out  1  one-cycle pulse on switch completion.

Behaviour:
- Reset:
  - active=0, wbs_ack_o=0, wbs_dat_o=0, irq=0.
  - FSM in OFF.
  - CTRL=0, GUARD=GUARD_DEFAULT, sticky bits=0.
  - Asserting reset mid-switch drops active to 0 immediately.
- Bus decode:
  - Hit when cyc&stb and wbs_adr_i[31:4]==BASE_ADDR[31:4].
  - wbs_ack_o pulses for 1 cycle, on the cycle after the hit is first seen.
  - No back-to-back ack: ack is masked in the cycle after an ack.
  - Out-of-window addresses are never acked, so other slaves can respond.
  - Register accesses take effect on the ack cycle.
- Registers (offset from BASE_ADDR):
  - 0x0 CTRL rw: [3:0] idx, [8] en. A write is a switch request.
  - 0x4 GUARD rw: [15:0] guard cycles G.
  - 0x8 STATUS: [3:0] current idx (ro), [8] on (ro), [9] busy (ro), [10] done (sticky, write-1-clear), [11] err (sticky, write-1-clear).
  - 0xC: reads 0, writes ignored.
- Request validation:
  - If en=1 and idx>=N_PROJ: set err, ignore the request, leave CTRL unchanged.
  - Otherwise latch target = {en, idx}.
- FSM states: OFF, ON, DRAIN.
  - OFF, request en=1 → ON next cycle. active=onehot(idx), irq pulse, done=1.
  - OFF, request en=0 → no-op.
  - ON, request with en=1 and same idx → no-op, no irq.
  - ON, any other request → DRAIN. active=0 from the next cycle. Counter loads max(G,1).
  - DRAIN: counter decrements each cycle. When it reaches 0:
    - goes to ON(target) if target.en, otherwise to OFF;
    - irq pulse, done=1.
  - DRAIN therefore holds all enables low for exactly max(G,1) cycles.
  - A new valid request during DRAIN replaces the target. The counter is not restarted.
  - GUARD writes during DRAIN affect only the next switch.
- busy=1 in DRAIN only.
- irq and a write-1-clear of done in the same cycle: set wins.
- Counter is 16 bits wide. G=0xFFFF gives 65535 cycles with no wrap.

Test Plan:
- Reset with G=16:
  - read GUARD → 16;
  - read STATUS → 0;
  - active=0;
  - read at BASE_ADDR+0x20 → no ack.
- From OFF, write CTRL=0x100 (en, idx 0):
  - active=2'b01 one cycle after ack;
  - irq pulse;
  - STATUS → 0x500.
- From ON(0), write GUARD=3, then CTRL=0x101:
  - active=0 for exactly 3 cycles, then 2'b10;
  - irq pulse in the cycle active becomes 2'b10;
  - busy=1 during the gap.
- During DRAIN toward idx 1, write CTRL=0x000:
  - ends in OFF with active=0 at the original counter expiry;
  - 1 irq total.
- With N_PROJ=2, write CTRL=0x105:
  - err=1, state and active unchanged;
  - write 0x800 to STATUS → err clears.
- G=0 switch 0→1:
  - exactly 1 all-zero cycle;
  - asserting wb_rst_ni low mid-DRAIN → active=0 and STATUS=0 asynchronously.
